// File: rtl/tx_packet_queue.sv
// tx_packet_queue: four-entry packet FIFO feeding a serial transmitter.
// The oldest packet is mirrored into a dedicated head register that drives
// TX_Data, so the transmitter sees a registered value that only changes when
// the head is replaced. Count includes the head entry.
module tx_packet_queue (
  input  logic        Clk_S,
  input  logic        Rst_n,
  input  logic [54:0] In_Data,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic        Flush,
  output logic [54:0] TX_Data,
  output logic        TX_Data_Valid,
  input  logic        TX_Ready,
  output logic [2:0]  Count,
  output logic [7:0]  Sent_Count
);

  localparam int DEPTH = 4;

  // Packet storage; every queued packet (head included) lives here.
  logic [54:0] r_mem [DEPTH];

  logic [1:0]  r_rd_ptr;
  logic [1:0]  r_wr_ptr;
  logic [2:0]  r_count;
  logic        r_valid;
  logic [54:0] r_tx_data;
  logic [7:0]  r_sent;

  logic        w_in_ready;
  logic        w_push;
  logic        w_pop;
  logic [2:0]  w_remaining;
  logic [2:0]  w_count_next;
  logic [1:0]  w_rd_ptr_next;
  logic [1:0]  w_wr_ptr_next;
  logic [54:0] w_head_next;
  logic        w_head_load;

  // Space is judged on the current occupancy only, so a pop on the same edge
  // never frees room for a push into a full queue.
  assign w_in_ready = (r_count < 3'd4);
  assign w_push     = In_Valid & w_in_ready & ~Flush;
  // A pop is a completed handoff and is honoured even when Flush is high.
  assign w_pop      = r_valid & TX_Ready;
  // Occupancy once the outgoing head (if any) has left.
  assign w_remaining = r_count - {2'b00, w_pop};

  // Next-state pointers, occupancy and the value that will sit at the head.
  always_comb begin
    w_count_next  = w_remaining + {2'b00, w_push};
    w_rd_ptr_next = r_rd_ptr + {1'b0, w_pop};
    w_wr_ptr_next = r_wr_ptr + {1'b0, w_push};
    w_head_next   = r_mem[w_rd_ptr_next];
    w_head_load   = 1'b0;
    // When nothing older survives the edge, the packet arriving now is the
    // new head; it is not yet in storage so take it straight from the input.
    if (w_remaining == 3'd0) begin
      w_head_next = In_Data;
    end
    if (Flush) begin
      w_count_next  = 3'd0;
      w_rd_ptr_next = 2'd0;
      w_wr_ptr_next = 2'd0;
    end
    // Reload only while something stays queued; otherwise TX_Data keeps its
    // last value (also across a flush).
    if (!Flush && (w_count_next != 3'd0)) begin
      w_head_load = 1'b1;
    end
  end

  // Storage write; contents need no reset because occupancy tracks validity.
  always_ff @(posedge Clk_S) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= In_Data;
    end
  end

  // Pointer, occupancy and valid-flag registers.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rd_ptr <= 2'd0;
      r_wr_ptr <= 2'd0;
      r_count  <= 3'd0;
      r_valid  <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_ptr_next;
      r_wr_ptr <= w_wr_ptr_next;
      r_count  <= w_count_next;
      r_valid  <= (w_count_next != 3'd0);
    end
  end

  // Head register presented to the transmitter.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      r_tx_data <= 55'd0;
    end else if (w_head_load) begin
      r_tx_data <= w_head_next;
    end
  end

  // Running count of completed handoffs, wrapping at 256.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      r_sent <= 8'd0;
    end else if (w_pop) begin
      r_sent <= r_sent + 8'd1;
    end
  end

  assign In_Ready      = w_in_ready;
  assign TX_Data       = r_tx_data;
  assign TX_Data_Valid = r_valid;
  assign Count         = r_count;
  assign Sent_Count    = r_sent;

endmodule

// File: tb/tb_tx_packet_queue.sv
// Directed bench for tx_packet_queue: a vector table for the single-edge
// behaviour plus hand-written sequences for reset, slow transmitter,
// Sent_Count wrap and mid-operation reset.
module tb_tx_packet_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [54:0] in_data = 55'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [54:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [2:0]  count;
  logic [7:0]  sent;

  int checks = 0;
  int failures = 0;

  tx_packet_queue dut (
    .Clk_S        (clk),
    .Rst_n        (rst_n),
    .In_Data      (in_data),
    .In_Valid     (in_valid),
    .In_Ready     (in_ready),
    .Flush        (flush),
    .TX_Data      (tx_data),
    .TX_Data_Valid(tx_valid),
    .TX_Ready     (tx_ready),
    .Count        (count),
    .Sent_Count   (sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [54:0] d;
    logic        r;
    logic        f;
    logic [2:0]  cnt;
    logic        val;
    logic [54:0] dat;
    logic        inr;
    logic [7:0]  snt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [54:0] d, input logic r, input logic f,
                     input logic [2:0] cnt, input logic val, input logic [54:0] dat,
                     input logic [7:0] snt);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.f = f;
    t.cnt = cnt; t.val = val; t.dat = dat; t.inr = (cnt != 3'd4); t.snt = snt;
    vecs.push_back(t);
  endtask

  task automatic check_state(input string tag, input logic [2:0] c, input logic v,
                             input logic [54:0] d, input logic ir, input logic [7:0] s);
    chk({tag, ".count"}, 64'(count), 64'(c));
    chk({tag, ".valid"}, 64'(tx_valid), 64'(v));
    chk({tag, ".data"}, 64'(tx_data), 64'(d));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(ir));
    chk({tag, ".sent"}, 64'(sent), 64'(s));
  endtask

  initial begin
    logic [54:0] pat_a;
    logic [54:0] pat_b;
    logic [54:0] popped [2];
    logic [7:0]  exp_sent;
    logic [54:0] pre_data;
    logic        pre_valid;
    logic        pop_now;
    int          hold;
    int          pops;
    int          n;

    // Table: start state after reset release is one packet (3) at the head.
    add(0, 55'd0,  1, 0, 0, 0, 55'd3,  8'd1);
    add(0, 55'd0,  0, 0, 0, 0, 55'd3,  8'd1);
    add(1, 55'd1,  0, 0, 1, 1, 55'd1,  8'd1);
    add(1, 55'd2,  0, 0, 2, 1, 55'd1,  8'd1);
    add(1, 55'd3,  0, 0, 3, 1, 55'd1,  8'd1);
    add(1, 55'd4,  0, 0, 4, 1, 55'd1,  8'd1);
    add(1, 55'd5,  0, 0, 4, 1, 55'd1,  8'd1);   // full: 5 refused
    add(1, 55'd5,  1, 0, 3, 1, 55'd2,  8'd2);   // full + pop: still no push
    add(0, 55'd0,  1, 0, 2, 1, 55'd3,  8'd3);
    add(0, 55'd0,  1, 0, 1, 1, 55'd4,  8'd4);
    add(0, 55'd0,  1, 0, 0, 0, 55'd4,  8'd5);
    add(1, 55'd10, 0, 0, 1, 1, 55'd10, 8'd5);
    add(1, 55'd11, 0, 0, 2, 1, 55'd10, 8'd5);
    add(1, 55'd12, 0, 0, 3, 1, 55'd10, 8'd5);
    add(1, 55'd13, 1, 1, 0, 0, 55'd10, 8'd6);   // flush + pop at count 3
    add(1, 55'd14, 0, 0, 1, 1, 55'd14, 8'd6);
    for (int i = 0; i < 10; i++) begin          // count 1 push+pop across wraps
      add(1, 55'(20 + i), 1, 0, 1, 1, 55'(20 + i), 8'(7 + i));
    end
    add(0, 55'd0,  1, 0, 0, 0, 55'd29, 8'd17);
    add(1, 55'd40, 0, 0, 1, 1, 55'd40, 8'd17);
    add(1, 55'd41, 0, 0, 2, 1, 55'd40, 8'd17);
    add(1, 55'd42, 1, 0, 2, 1, 55'd41, 8'd18);
    add(1, 55'd43, 0, 0, 3, 1, 55'd41, 8'd18);
    add(1, 55'd44, 1, 0, 3, 1, 55'd42, 8'd19);
    add(0, 55'd0,  1, 0, 2, 1, 55'd43, 8'd20);
    add(0, 55'd0,  1, 0, 1, 1, 55'd44, 8'd21);
    add(0, 55'd0,  1, 0, 0, 0, 55'd44, 8'd22);
    add(1, 55'd50, 0, 1, 0, 0, 55'd44, 8'd22);  // flush beats push

    // Asynchronous reset with a packet offered, checked before any edge.
    in_valid = 1'b1;
    in_data  = 55'd3;
    #2 rst_n = 1'b0;
    #1;
    check_state("reset_async", 3'd0, 1'b0, 55'd0, 1'b1, 8'd0);
    $display("reset asserted: count=%0d valid=%0b data=%0h sent=%0d", count, tx_valid, tx_data, sent);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_state("reset_release", 3'd1, 1'b1, 55'd3, 1'b1, 8'd0);
    $display("reset released: count=%0d valid=%0b data=%0h", count, tx_valid, tx_data);

    foreach (vecs[i]) begin
      in_valid = vecs[i].v;
      in_data  = vecs[i].d;
      tx_ready = vecs[i].r;
      flush    = vecs[i].f;
      @(posedge clk);
      @(negedge clk);
      check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].val, vecs[i].dat, vecs[i].inr, vecs[i].snt);
      $display("vec %0d: v=%0b d=%0h r=%0b f=%0b -> count=%0d valid=%0b data=%0h sent=%0d",
               i, vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].f, count, tx_valid, tx_data, sent);
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    tx_ready = 1'b0;
    exp_sent = 8'd22;

    // Slow transmitter: ready drops for 56 cycles after every accept.
    pat_a = 55'h2AAAAAAAAAAAAA;
    pat_b = 55'h5555555555555;
    popped[0] = 55'd0;
    popped[1] = 55'd0;
    hold = 0;
    pops = 0;
    for (int cyc = 0; cyc < 150; cyc++) begin
      in_valid = (cyc < 2);
      in_data  = (cyc == 0) ? pat_a : pat_b;
      tx_ready = (hold == 0);
      pre_valid = tx_valid;
      pre_data  = tx_data;
      pop_now   = tx_valid && tx_ready;
      if (pop_now) begin
        if (pops < 2) popped[pops] = tx_data;
        pops++;
        hold = 56;
        exp_sent = exp_sent + 8'd1;
      end else if (hold > 0) begin
        hold--;
      end
      @(posedge clk);
      @(negedge clk);
      if (pre_valid && !pop_now) chk("slow_stable", 64'(tx_data), 64'(pre_data));
      if (pop_now) $display("slow tx: accepted %0h at cycle %0d", pre_data, cyc);
    end
    in_valid = 1'b0;
    tx_ready = 1'b0;
    chk("slow_pops", 64'(pops), 64'd2);
    chk("slow_first", 64'(popped[0]), 64'(pat_a));
    chk("slow_second", 64'(popped[1]), 64'(pat_b));
    check_state("slow_end", 3'd0, 1'b0, pat_b, 1'b1, exp_sent);

    // Stream packets through until Sent_Count wraps back to zero.
    n = 256 - int'(exp_sent);
    for (int i = 0; i <= n; i++) begin
      in_valid = (i < n);
      in_data  = 55'(1000 + i);
      tx_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (i >= 1) exp_sent = exp_sent + 8'd1;
      if (i < n) begin
        chk("wrap_count", 64'(count), 64'd1);
        chk("wrap_head", 64'(tx_data), 64'(1000 + i));
      end
      chk("wrap_sent", 64'(sent), 64'(exp_sent));
      if (i == n - 1) chk("wrap_sent_255", 64'(sent), 64'd255);
      $display("wrap %0d: count=%0d data=%0h sent=%0d", i, count, tx_data, sent);
    end
    check_state("wrap_end", 3'd0, 1'b0, 55'(1000 + n - 1), 1'b1, 8'd0);
    tx_ready = 1'b0;

    // Reset in the middle of operation with three packets queued.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 55'(200 + i);
      @(posedge clk);
      @(negedge clk);
      $display("fill %0d: count=%0d data=%0h", i, count, tx_data);
    end
    in_valid = 1'b0;
    chk("mid_fill_count", 64'(count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check_state("mid_reset", 3'd0, 1'b0, 55'd0, 1'b1, 8'd0);
    $display("mid reset: count=%0d valid=%0b data=%0h sent=%0d", count, tx_valid, tx_data, sent);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 55'd77;
    @(posedge clk);
    @(negedge clk);
    check_state("after_reset_push", 3'd1, 1'b1, 55'd77, 1'b1, 8'd0);
    in_valid = 1'b0;
    tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_state("after_reset_empty", 3'd0, 1'b0, 55'd77, 1'b1, 8'd1);
    $display("post reset drain: count=%0d valid=%0b sent=%0d", count, tx_valid, sent);
    tx_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
